// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Package  : datapath_pkg
// Brief    : Opcodes, bus indices and FSM state encoding shared by the
//            datapath controller and its decoder.
// Revision : 1.0
// ============================================================================
package datapath_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Bit positions on the 16-bit rout/ren buses
    localparam logic [3:0] IDX_G      = 4'd8;
    localparam logic [3:0] IDX_A      = 4'd9;
    localparam logic [3:0] IDX_EXTERN = 4'd10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EX1    = 3'd3,
        EX2    = 3'd4,
        EX3    = 3'd5
`ifdef DATAPATH_CONTROLLER_STEP_EN
        ,WAIT  = 3'd6
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/datapath_dec3to8.sv
`default_nettype none
// ============================================================================
// Module   : datapath_dec3to8
// Brief    : 3-to-8 one-hot decoder with enable; all zeros when disabled.
// Revision : 1.0
// ============================================================================
module datapath_dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/datapath_controller.sv
`default_nettype none
// ============================================================================
// Module   : datapath_controller
// Brief    : Multi-cycle fetch/decode/execute controller for an 8-register
//            datapath; every output comes straight from a flip-flop.
// Options  : DATAPATH_CONTROLLER_STEP_EN adds input step and a WAIT state.
// Revision : 1.0
// ============================================================================
module datapath_controller
    import datapath_pkg::*;
(
    input  logic        clock,
    input  logic        resetnot,
    input  logic        run,
`ifdef DATAPATH_CONTROLLER_STEP_EN
    input  logic        step,
`endif
    input  logic [7:0]  instruction,
    output logic [15:0] rout,
    output logic [15:0] ren,
    output logic        addxor,
    output logic        increment,
    output logic        busy,
    output logic        done,
    output logic [15:0] instr_count
);

    state_t      r_state;
    state_t      w_state_nx;
    state_t      w_after_last;

    logic [7:0]  r_ir;
    logic [7:0]  w_ir_nx;
    logic [7:0]  w_rx_oh;
    logic [7:0]  w_ry_oh;
    logic        w_dec_en;

    logic [15:0] r_rout;
    logic [15:0] w_rout_nx;
    logic [15:0] r_ren;
    logic [15:0] w_ren_nx;
    logic [15:0] r_instr_count;
    logic [15:0] w_count_nx;
    logic        r_addxor;
    logic        w_addxor_nx;
    logic        r_increment;
    logic        w_increment_nx;
    logic        r_busy;
    logic        r_done;
    logic        w_done_nx;

`ifdef DATAPATH_CONTROLLER_STEP_EN
    assign w_after_last = run ? WAIT : IDLE;
`else
    assign w_after_last = run ? FETCH : IDLE;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (run) w_state_nx = FETCH;
            FETCH:   w_state_nx = DECODE;
            DECODE:  w_state_nx = EX1;
            EX1:     w_state_nx = (r_ir[7:6] inside {OP_ADD, OP_XOR}) ? EX2 : w_after_last;
            EX2:     w_state_nx = EX3;
            EX3:     w_state_nx = w_after_last;
`ifdef DATAPATH_CONTROLLER_STEP_EN
            WAIT: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end else if (step) begin
                    w_state_nx = FETCH;
                end
            end
`endif
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed for the state being entered;
    // on the DECODE->EX1 edge that means the instruction IR is about to hold.
    assign w_ir_nx  = (r_state == DECODE) ? instruction : r_ir;
    assign w_dec_en = (w_state_nx == EX1) || (w_state_nx == EX2) || (w_state_nx == EX3);

    datapath_dec3to8 u_dec_rx (
        .en     (w_dec_en),
        .sel    (w_ir_nx[5:3]),
        .onehot (w_rx_oh)
    );

    datapath_dec3to8 u_dec_ry (
        .en     (w_dec_en),
        .sel    (w_ir_nx[2:0]),
        .onehot (w_ry_oh)
    );

    always_comb begin
        w_rout_nx      = 16'h0000;
        w_ren_nx       = 16'h0000;
        w_addxor_nx    = 1'b0;
        w_increment_nx = 1'b0;
        w_done_nx      = 1'b0;
        case (w_state_nx)
            FETCH: w_increment_nx = 1'b1;
            EX1: begin
                if (w_ir_nx[7:6] == OP_MV) begin
                    w_rout_nx[7:0] = w_ry_oh;
                    w_ren_nx[7:0]  = w_rx_oh;
                    w_done_nx      = 1'b1;
                end else if (w_ir_nx[7:6] == OP_MVI) begin
                    w_rout_nx[IDX_EXTERN] = 1'b1;
                    w_ren_nx[7:0]         = w_rx_oh;
                    w_done_nx             = 1'b1;
                end else begin
                    w_rout_nx[7:0]   = w_rx_oh;
                    w_ren_nx[IDX_A]  = 1'b1;
                end
            end
            EX2: begin
                w_rout_nx[7:0]  = w_ry_oh;
                w_ren_nx[IDX_G] = 1'b1;
                w_addxor_nx     = w_ir_nx[6];
            end
            EX3: begin
                w_rout_nx[IDX_G] = 1'b1;
                w_ren_nx[7:0]    = w_rx_oh;
                w_done_nx        = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_count_nx = r_instr_count + {15'd0, w_done_nx};

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_ir          <= 8'h00;
            r_rout        <= 16'h0000;
            r_ren         <= 16'h0000;
            r_addxor      <= 1'b0;
            r_increment   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_instr_count <= 16'h0000;
        end else begin
            r_ir          <= w_ir_nx;
            r_rout        <= w_rout_nx;
            r_ren         <= w_ren_nx;
            r_addxor      <= w_addxor_nx;
            r_increment   <= w_increment_nx;
            r_busy        <= (w_state_nx != IDLE);
            r_done        <= w_done_nx;
            r_instr_count <= w_count_nx;
        end
    end

    assign rout        = r_rout;
    assign ren         = r_ren;
    assign addxor      = r_addxor;
    assign increment   = r_increment;
    assign busy        = r_busy;
    assign done        = r_done;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_datapath_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_controller
// Brief    : Directed self-checking bench with an instruction-level model;
//            define DATAPATH_CONTROLLER_STEP_EN to exercise single-step mode.
// Revision : 1.0
// ============================================================================
module tb_datapath_controller;

    logic        clock       = 1'b0;
    logic        resetnot    = 1'b0;
    logic        run         = 1'b0;
    logic [7:0]  instruction = 8'h00;
`ifdef DATAPATH_CONTROLLER_STEP_EN
    logic        step        = 1'b0;
`endif
    logic [15:0] rout;
    logic [15:0] ren;
    logic        addxor;
    logic        increment;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    datapath_controller dut (
        .clock       (clock),
        .resetnot    (resetnot),
        .run         (run),
`ifdef DATAPATH_CONTROLLER_STEP_EN
        .step        (step),
`endif
        .instruction (instruction),
        .rout        (rout),
        .ren         (ren),
        .addxor      (addxor),
        .increment   (increment),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Instruction-level model: each instruction expands into a list of
    // expected per-cycle output records.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] ren;
        logic        addxor;
        logic        inc;
        logic        busy;
        logic        done;
    } outs_t;

    outs_t       m_cur       = '0;
    outs_t       m_q[$];
    logic        m_in_decode = 1'b0;
    logic        m_wait      = 1'b0;
    int          m_done      = 0;
    logic [15:0] m_base      = 16'h0000;

    function automatic outs_t mk(input logic [15:0] r, input logic [15:0] e,
                                 input logic ax, input logic inc,
                                 input logic bsy, input logic dn);
        outs_t o;
        o.rout = r; o.ren = e; o.addxor = ax; o.inc = inc; o.busy = bsy; o.done = dn;
        return o;
    endfunction

    task automatic expand(input logic [7:0] ins);
        logic [15:0] bx;
        logic [15:0] by;
        bx = 16'd1 << ins[5:3];
        by = 16'd1 << ins[2:0];
        case (ins[7:6])
            2'b00: m_q.push_back(mk(by, bx, 1'b0, 1'b0, 1'b1, 1'b1));
            2'b01: m_q.push_back(mk(16'h0400, bx, 1'b0, 1'b0, 1'b1, 1'b1));
            default: begin
                m_q.push_back(mk(bx, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0));
                m_q.push_back(mk(by, 16'h0100, ins[6], 1'b0, 1'b1, 1'b0));
                m_q.push_back(mk(16'h0100, bx, 1'b0, 1'b0, 1'b1, 1'b1));
            end
        endcase
    endtask

    task automatic push_fetch();
        m_q.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0));
        m_q.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic model_advance();
        if (m_in_decode) expand(instruction);
        m_in_decode = 1'b0;
        if (m_q.size() == 0) begin
`ifdef DATAPATH_CONTROLLER_STEP_EN
            if (m_wait) begin
                if (!run) begin
                    m_wait = 1'b0;
                end else if (step) begin
                    m_wait = 1'b0;
                    push_fetch();
                end
            end else if (run && m_cur.done) begin
                m_wait = 1'b1;
            end else if (run) begin
                push_fetch();
            end
`else
            if (run) push_fetch();
`endif
        end
        if (m_q.size() != 0) begin
            m_cur = m_q.pop_front();
            // The decode record is the only non-final record that empties the list
            m_in_decode = (m_q.size() == 0) && !m_cur.done;
            if (m_cur.done) m_done++;
        end else begin
            m_cur = m_wait ? mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0) : '0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge resetnot);
            if (!resetnot) begin
                m_q.delete();
                m_cur       = '0;
                m_in_decode = 1'b0;
                m_wait      = 1'b0;
                m_done      = 0;
            end else begin
                model_advance();
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        logic [63:0] exp_v;
        logic [63:0] act_v;
        forever begin
            @(posedge clock);
            #4;
            exp_v = {12'd0, m_cur.rout, m_cur.ren, m_cur.addxor, m_cur.inc,
                     m_cur.busy, m_cur.done, 16'(m_base + 16'(m_done))};
            act_v = {12'd0, rout, ren, addxor, increment, busy, done, instr_count};
            check("cycle_model", act_v, exp_v);
            check("rout_onehot", {63'd0, ($countones(rout) <= 1)}, 64'd1);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_out(input string name, input logic [15:0] e_rout, input logic [15:0] e_ren,
                           input logic e_ax, input logic e_inc, input logic e_busy, input logic e_done);
        check(name, {28'd0, rout, ren, addxor, increment, busy, done},
                    {28'd0, e_rout, e_ren, e_ax, e_inc, e_busy, e_done});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) cyc();
        chk_out("reset_outputs", 16'h0000, 16'h0000, 0, 0, 0, 0);
        check("reset_count", {48'd0, instr_count}, 64'd0);
        resetnot = 1'b1;
        cyc();
        chk_out("idle_no_run", 16'h0000, 16'h0000, 0, 0, 0, 0);

        // mvi r3,#5 ; run dropped during FETCH still completes the instruction
        instruction = 8'b01_011_101; run = 1'b1;
        cyc(); chk_out("mvi_fetch", 16'h0000, 16'h0000, 0, 1, 1, 0);
        run = 1'b0;
        cyc(); chk_out("mvi_decode", 16'h0000, 16'h0000, 0, 0, 1, 0);
        cyc(); chk_out("mvi_ex1", 16'h0400, 16'h0008, 0, 0, 1, 1);
        check("mvi_count", {48'd0, instr_count}, 64'd1);
        cyc(); chk_out("mvi_idle", 16'h0000, 16'h0000, 0, 0, 0, 0);

        // add r2,r1 ; live instruction corrupted after DECODE must not matter
        instruction = 8'b10_010_001; run = 1'b1;
        cyc(); run = 1'b0;
        cyc();
        cyc(); chk_out("add_ex1", 16'h0004, 16'h0200, 0, 0, 1, 0);
        instruction = 8'hFF;
        cyc(); chk_out("add_ex2", 16'h0002, 16'h0100, 0, 0, 1, 0);
        cyc(); chk_out("add_ex3", 16'h0100, 16'h0004, 0, 0, 1, 1);
        check("add_count", {48'd0, instr_count}, 64'd2);
        cyc(); chk_out("add_idle", 16'h0000, 16'h0000, 0, 0, 0, 0);

        // xor r0,r7 followed directly by mv r3,r3
        instruction = 8'b11_000_111; run = 1'b1;
        cyc(); cyc();
        cyc(); chk_out("xor_ex1", 16'h0001, 16'h0200, 0, 0, 1, 0);
        cyc(); chk_out("xor_ex2", 16'h0080, 16'h0100, 1, 0, 1, 0);
        cyc(); chk_out("xor_ex3", 16'h0100, 16'h0001, 0, 0, 1, 1);
        instruction = 8'b00_011_011;
`ifdef DATAPATH_CONTROLLER_STEP_EN
        repeat (5) begin
            cyc(); chk_out("wait_hold", 16'h0000, 16'h0000, 0, 0, 1, 0);
        end
        step = 1'b1;
        cyc(); step = 1'b0;
        chk_out("step_fetch", 16'h0000, 16'h0000, 0, 1, 1, 0);
`else
        cyc(); chk_out("b2b_fetch", 16'h0000, 16'h0000, 0, 1, 1, 0);
`endif
        cyc(); run = 1'b0;
        cyc(); chk_out("mv_nop_ex1", 16'h0008, 16'h0008, 0, 0, 1, 1);
        check("mv_count", {48'd0, instr_count}, 64'd4);
        cyc(); chk_out("mv_idle", 16'h0000, 16'h0000, 0, 0, 0, 0);

        // Asynchronous reset in EX2 of add r1,r4
        instruction = 8'b10_001_100; run = 1'b1;
        cyc(); cyc(); cyc();
        cyc(); chk_out("rst_pre_ex2", 16'h0010, 16'h0100, 0, 0, 1, 0);
        resetnot = 1'b0;
        #1;
        chk_out("rst_async", 16'h0000, 16'h0000, 0, 0, 0, 0);
        check("rst_count", {48'd0, instr_count}, 64'd0);
        cyc(); chk_out("rst_hold", 16'h0000, 16'h0000, 0, 0, 0, 0);
        resetnot = 1'b1;
        cyc(); chk_out("first_fetch", 16'h0000, 16'h0000, 0, 1, 1, 0);
        run = 1'b0;
        repeat (5) cyc();
        chk_out("post_rst_idle", 16'h0000, 16'h0000, 0, 0, 0, 0);

        // Counter wrap: preload 0xFFFF, then xor r5,r6 with run dropped in EX1
        force dut.r_instr_count = 16'hFFFF;
        m_base = 16'hFFFF - 16'(m_done);
        cyc(); cyc();
        release dut.r_instr_count;
        check("preload", {48'd0, instr_count}, 64'h0000_0000_0000_FFFF);
        instruction = 8'b11_101_110; run = 1'b1;
        cyc(); cyc();
        cyc(); chk_out("xor2_ex1", 16'h0020, 16'h0200, 0, 0, 1, 0);
        run = 1'b0;
        cyc(); chk_out("xor2_ex2", 16'h0040, 16'h0100, 1, 0, 1, 0);
        cyc(); chk_out("xor2_ex3", 16'h0100, 16'h0020, 0, 0, 1, 1);
        check("wrap_count", {48'd0, instr_count}, 64'd0);
        cyc(); chk_out("xor2_idle", 16'h0000, 16'h0000, 0, 0, 0, 0);
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 The module SHALL have these ports, with clock and reset first:
- clock  in  1  sole clock; all state changes on its rising edge.
- resetnot  in  1  asynchronous, active-low reset.
- run  in  1  level; when high, the controller fetches and executes instructions.
- instruction  in  8  current instruction from the datapath; [7:6] opcode, [5:3] rX, [2:0] rY or imm.
- rout  out  16  one-hot bus-driver select; [7:0] R0-R7, [8] G, [9] A, [10] EXTERN, [15:11] always 0.
- ren  out  16  register load enables; [7:0] R0-R7, [8] G, [9] A, [15:10] always 0.
- addxor  out  1  ALU op; 0 = add, 1 = xor.
- increment  out  1  program-counter advance; the datapath acts on its rising edge.
- busy  out  1  high while the FSM is outside IDLE.
- done  out  1  one-cycle pulse in the last execute cycle of each instruction.
- instr_count  out  16  count of completed instructions; wraps.

REQ-002 Reset SHALL be asynchronous and active-low on port resetnot; the module SHALL have exactly one clock, named clock.

Function
REQ-003 All outputs SHALL be driven directly from flip-flops, so that increment and enables are glitch-free.
REQ-004 States SHALL be: IDLE, FETCH, DECODE, EX1, EX2, EX3.
REQ-005 Transitions from IDLE, FETCH and DECODE:
- IDLE -> FETCH when run=1; otherwise stay in IDLE.
- FETCH -> DECODE unconditionally.
- DECODE -> EX1 unconditionally.
REQ-006 In FETCH, increment=1 for exactly one cycle and all rout/ren bits SHALL be 0.
REQ-007 In DECODE, an internal IR SHALL capture instruction at the closing clock edge; EX states SHALL use IR only, never the live instruction input.
REQ-008 Opcode 00 (mv rX,rY): in EX1, rout[rY]=1 and ren[rX]=1; this is the last execute cycle.
REQ-009 Opcode 01 (mvi rX,imm): in EX1, rout[10]=1 and ren[rX]=1; this is the last execute cycle.
REQ-010 Opcodes 10 (add) and 11 (xor) SHALL use three execute cycles:
- EX1: rout[rX]=1, ren[9]=1.
- EX2: rout[rY]=1, ren[8]=1, addxor=IR[6].
- EX3: rout[8]=1, ren[rX]=1; this is the last execute cycle.
REQ-011 addxor SHALL be 0 in every state except EX2.
REQ-012 In the last execute cycle of an instruction:
- done=1 and instr_count increments by 1 (0xFFFF wraps to 0x0000).
- The next state is FETCH if run=1, else IDLE.
REQ-013 Deasserting run mid-instruction SHALL NOT abort the instruction; it completes, then the FSM goes to IDLE.
REQ-014 At most one rout bit SHALL be high in any cycle.
REQ-015 mv with rX=rY is legal and SHALL execute normally (it is a nop).
REQ-016 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-017 While resetnot=0, the following SHALL hold immediately, with no clock edge needed:
- state=IDLE, IR=0.
- rout=0, ren=0, addxor=0, increment=0, done=0, instr_count=0.
REQ-018 Reset asserted mid-instruction SHALL abandon the instruction; no partial write may occur after reset asserts.
REQ-019 The first FETCH SHALL occur at the first rising clock edge after resetnot=1 with run=1.

Configuration
REQ-020 With macro DATAPATH_CONTROLLER_STEP_EN defined:
- Add input step (1 bit) and state WAIT.
- After each last execute cycle with run=1, the FSM enters WAIT instead of FETCH.
- WAIT -> FETCH on a cycle where step=1; WAIT -> IDLE if run=0.
- In WAIT, busy=1 and all other outputs are 0.
REQ-021 Without the macro, port step and state WAIT SHALL NOT exist, and behaviour SHALL be as in REQ-012.

Structure
REQ-022 Shared package datapath_pkg SHALL hold:
- Opcode constants: OP_MV=2'b00, OP_MVI=2'b01, OP_ADD=2'b10, OP_XOR=2'b11.
- The state enumeration.
- Bus index constants: IDX_G=8, IDX_A=9, IDX_EXTERN=10.
REQ-023 One sub-module datapath_dec3to8 (3-bit to 8-bit one-hot decoder, with enable) SHALL be instantiated twice: once for rX, once for rY.

Verification
REQ-024 Reset: resetnot=0 mid-EX2 of an add -> all outputs 0 immediately; state IDLE; instr_count=0.
REQ-025 mvi: instruction=8'b01_011_101, run=1 -> cycle sequence:
- FETCH: increment=1.
- DECODE.
- EX1: rout=0x0400, ren=0x0008, done=1.
REQ-026 add: instruction=8'b10_010_001 -> execute cycles:
- EX1: rout=0x0004, ren=0x0200, addxor=0.
- EX2: rout=0x0002, ren=0x0100, addxor=0.
- EX3: rout=0x0100, ren=0x0004, done=1.
REQ-027 xor: instruction=8'b11_000_111 -> EX2: rout=0x0080, ren=0x0100, addxor=1.
REQ-028 run dropped during EX1 of an xor -> EX2 and EX3 still execute, then IDLE with busy=0; instr_count preloaded to 0xFFFF wraps to 0x0000.
REQ-029 With DATAPATH_CONTROLLER_STEP_EN defined: after a mv, the FSM holds in WAIT for 5 cycles with step=0; a single step=1 cycle -> FETCH on the next edge.
